// File: rtl/wb_pkg.sv
// Shared types and default constants for the Wishbone classic initiator.
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } wb_state_e;

  localparam int unsigned DefAddrWidth     = 10;
  localparam int unsigned DefDataWidth     = 8;
  localparam int unsigned DefTimeoutCycles = 16;
  localparam int unsigned TimeoutCntWidth  = 8;

endpackage

// File: rtl/wb_timeout.sv
// Ack wait counter: cleared on command acceptance, counts bus cycles without ack.
module wb_timeout
  import wb_pkg::*;
#(
  parameter int unsigned Timeout = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TimeoutCntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High on the edge where the count would reach Timeout.
  assign expired_o = enable_i && (cnt_q == TimeoutCntWidth'(Timeout - 1));

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator bridging a valid/ready command
// stream to the bus and returning read data or a timeout error.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_we_o,
  output logic                  wb_cycle_o,
  output logic                  wb_strobe_o,
  input  logic                  wb_ack_i
);

  wb_state_e             state_q;
  logic                  ready_q;
  logic                  cyc_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic accept;
  logic wait_en;
  logic expired;

  assign accept  = cmd_valid_i && ready_q;
  assign wait_en = (state_q == StBus) && !wb_ack_i;

  wb_timeout #(
    .Timeout (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (wb_clock_i),
    .rst_ni    (wb_reset_i),
    .clear_i   (accept),
    .enable_i  (wait_en),
    .expired_o (expired)
  );

  // ready_q resets low so cmd_ready_o only rises on the first edge after reset release.
  always_ff @(posedge wb_clock_i or negedge wb_reset_i) begin
    if (!wb_reset_i) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (accept) begin
            state_q <= StBus;
            ready_q <= 1'b0;
            cyc_q   <= 1'b1;
            we_q    <= cmd_we_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_data_i;
          end
        end
        StBus: begin
          // Ack takes priority over a simultaneous timeout.
          if (wb_ack_i) begin
            state_q     <= StResp;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= we_q ? '0 : wb_data_i;
          end else if (expired) begin
            state_q     <= StResp;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_we_o     = we_q;
  assign wb_cycle_o  = cyc_q;
  assign wb_strobe_o = cyc_q;

endmodule
